// File: rtl/sha256_multiblock.sv
// sha256_multiblock: multi-block SHA-256 over shared word memory.
// Pads in hardware, streams W through a 16-word window, writes H0..H7.
module sha256_multiblock #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int          NB     = (NUM_OF_WORDS + 18) / 16;
  localparam logic [15:0] N16    = 16'(NUM_OF_WORDS);
  localparam logic [15:0] LAST_P = 16'(16 * NB - 1);
  localparam logic [11:0] LAST_B = 12'(NB - 1);
  localparam logic [31:0] BITLEN = 32'(32 * NUM_OF_WORDS);

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [2:0] {
    IDLE, READ, COMPUTE, UPDATE, WRITE
  } state_t;

  function automatic logic [31:0] rotr(
    input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sm_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sm_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [11:0] blk_q, blk_d;
  logic [15:0] msg_q, msg_d;
  logic [15:0] out_q, out_d;
  logic [31:0] h_q [8];
  logic [31:0] h_d [8];
  logic [31:0] v_q [8];
  logic [31:0] v_d [8];
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  logic        done_q, done_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [15:0] p_idx;
  logic [31:0] rd_word;
  logic [31:0] t1, t2, w_new;

  assign mem_clk        = clk;
  assign done           = done_q;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;

  // Padded word for the datum returned this cycle.
  always_comb begin
    p_idx = {blk_q, 4'b0} + {9'b0, cnt_q} - 16'd1;
    if (p_idx < N16)         rd_word = mem_read_data;
    else if (p_idx == N16)   rd_word = 32'h8000_0000;
    else if (p_idx == LAST_P) rd_word = BITLEN;
    else                     rd_word = '0;
  end

  // One compression round and the next schedule word.
  always_comb begin
    t1 = v_q[7] + big_s1(v_q[4])
       + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
       + K[cnt_q[5:0]] + w_q[0];
    t2 = big_s0(v_q[0])
       + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2])
       ^ (v_q[1] & v_q[2]));
    w_new = sm_s1(w_q[14]) + w_q[9]
          + sm_s0(w_q[1]) + w_q[0];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    msg_d   = msg_q;
    out_d   = out_q;
    h_d     = h_q;
    v_d     = v_q;
    w_d     = w_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          msg_d   = message_addr;
          out_d   = output_addr;
          h_d     = IV;
          blk_d   = '0;
          cnt_d   = '0;
          addr_d  = message_addr;
        end
      end
      READ: begin
        if (cnt_q != 7'd0) begin
          for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
          w_d[15] = rd_word;
        end
        if (cnt_q < 7'd15) addr_d = addr_q + 16'd1;
        if (cnt_q == 7'd16) begin
          state_d = COMPUTE;
          cnt_d   = '0;
          v_d     = h_q;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      COMPUTE: begin
        v_d[7] = v_q[6];
        v_d[6] = v_q[5];
        v_d[5] = v_q[4];
        v_d[4] = v_q[3] + t1;
        v_d[3] = v_q[2];
        v_d[2] = v_q[1];
        v_d[1] = v_q[0];
        v_d[0] = t1 + t2;
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = w_new;
        if (cnt_q == 7'd63) begin
          state_d = UPDATE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      UPDATE: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + v_q[i];
        cnt_d = '0;
        if (blk_q != LAST_B) begin
          blk_d   = blk_q + 12'd1;
          state_d = READ;
          addr_d  = msg_q + {blk_d, 4'b0};
        end else begin
          state_d = WRITE;
          we_d    = 1'b1;
          addr_d  = out_q;
          wdata_d = h_q[0] + v_q[0];
        end
      end
      WRITE: begin
        if (cnt_q == 7'd7) begin
          state_d = IDLE;
        end else begin
          we_d    = 1'b1;
          cnt_d   = cnt_q + 7'd1;
          addr_d  = addr_q + 16'd1;
          wdata_d = h_q[cnt_q[2:0] + 3'd1];
        end
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_q == IDLE) && (state_d == IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      msg_q   <= '0;
      out_q   <= '0;
      h_q     <= '{default: '0};
      v_q     <= '{default: '0};
      w_q     <= '{default: '0};
      done_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      msg_q   <= msg_d;
      out_q   <= out_d;
      h_q     <= h_d;
      v_q     <= v_d;
      w_q     <= w_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_sha256_multiblock.sv
// tb_sha256_multiblock: four engine sizes on one shared memory,
// checked cycle by cycle against a byte-level SHA-256 model.
module tb_sha256_multiblock;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IVT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] ABCD [8] = '{
    32'h88d4266f, 32'hd4e6338d, 32'h13b845fc, 32'hf289579d,
    32'h209c8978, 32'h23b9217d, 32'ha3e16193, 32'h6f031589
  };

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] msg_a;
  logic [15:0] out_a;
  logic [31:0] rdata;
  logic        done_v [4];
  logic        mclk_v [4];
  logic        we_v [4];
  logic [15:0] addr_v [4];
  logic [31:0] wd_v [4];

  logic [31:0] img [65536];
  logic [31:0] exp_dg [8];
  logic [31:0] wr_cap [8];
  int act, k, p_cur, b_cur, first_done;
  logic track;
  int total, bad;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha256_multiblock #(
      .NUM_OF_WORDS(g == 0 ? 1 : g == 1 ? 20 : g == 2 ? 13 : 14)
    ) u_dut (
      .clk(clk),
      .reset_n(reset_n),
      .start(start && act == g),
      .message_addr(msg_a),
      .output_addr(out_a),
      .done(done_v[g]),
      .mem_clk(mclk_v[g]),
      .mem_we(we_v[g]),
      .mem_addr(addr_v[g]),
      .mem_write_data(wd_v[g]),
      .mem_read_data(rdata)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous read port driven by the active engine.
  always @(posedge clk) rdata <= img[addr_v[act]];

  function automatic int nw(input int g);
    return g == 0 ? 1 : g == 1 ? 20 : g == 2 ? 13 : 14;
  endfunction

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s k=%0d got=%h want=%h", nm, k, got, want);
    end
  endtask

  // Reference digest: standard byte-oriented SHA-256 padding.
  task automatic compute_expected(input int n, input logic [15:0] ma);
    logic [7:0]  by [$];
    logic [31:0] w [64];
    logic [31:0] h [8];
    logic [31:0] v [8];
    logic [31:0] x, t1, t2;
    logic [63:0] bl;
    logic [15:0] ad;
    for (int i = 0; i < n; i++) begin
      ad = ma + 16'(i);
      x = img[ad];
      for (int j = 3; j >= 0; j--) by.push_back(x[8*j +: 8]);
    end
    by.push_back(8'h80);
    while (by.size() % 64 != 56) by.push_back(8'h00);
    bl = 64'(n) * 64'd32;
    for (int j = 7; j >= 0; j--) by.push_back(bl[8*j +: 8]);
    h = IVT;
    for (int b = 0; b < by.size() / 64; b++) begin
      for (int t = 0; t < 16; t++)
        w[t] = {by[64*b+4*t], by[64*b+4*t+1],
                by[64*b+4*t+2], by[64*b+4*t+3]};
      for (int t = 16; t < 64; t++)
        w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10))
             + w[t-7]
             + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3))
             + w[t-16];
      v = h;
      for (int t = 0; t < 64; t++) begin
        t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
        t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        v[7] = v[6]; v[6] = v[5]; v[5] = v[4];
        v[4] = v[3] + t1;
        v[3] = v[2]; v[2] = v[1]; v[1] = v[0];
        v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) h[i] = h[i] + v[i];
    end
    exp_dg = h;
  endtask

  // Per-cycle compare of every engine against the run timeline.
  task automatic cmp();
    int j, b, c;
    logic [15:0] ea;
    for (int g = 0; g < 4; g++)
      if (!(track && g == act))
        chk($sformatf("idle_we%0d", g), 32'(we_v[g]), 32'd0);
    if (track) begin
      chk("done", 32'(done_v[act]), 32'(k >= p_cur));
      if (done_v[act] && first_done < 0) first_done = k;
      j = k - 82 * b_cur;
      chk("mem_we", 32'(we_v[act]), 32'(j >= 0 && j < 8));
      if (j >= 0 && j < 8) begin
        chk("wr_addr", 32'(addr_v[act]), 32'(out_a + 16'(j)));
        chk("wr_data", wd_v[act], exp_dg[j]);
        wr_cap[j] = wd_v[act];
      end else if (j < 0) begin
        b = k / 82;
        c = k % 82;
        if (c < 16) begin
          ea = msg_a + 16'(16 * b + c);
          chk("rd_addr", 32'(addr_v[act]), 32'(ea));
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmp();
    @(posedge clk);
    #1;
    if (track) k++;
  endtask

  // One run; optional mid-run pulse, held restart, or reset.
  task automatic run(input int g, input logic [15:0] ma,
                     input logic [15:0] oa, input int pulse_k,
                     input int hold_k, input int rst_k);
    act = g;
    msg_a = ma;
    out_a = oa;
    b_cur = (nw(g) + 18) / 16;
    p_cur = 82 * b_cur + 9;
    compute_expected(nw(g), ma);
    start = 1'b1;
    tick();
    start = 1'b0;
    track = 1'b1;
    k = 0;
    first_done = -1;
    for (int i = 0; i < 1000; i++) begin
      if (k == rst_k) begin
        #2 reset_n = 1'b0;
        #1;
        chk("rst_done", 32'(done_v[g]), 32'd1);
        chk("rst_we", 32'(we_v[g]), 32'd0);
        track = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (200) tick();
        return;
      end
      start = (k == pulse_k) || (hold_k >= 0 && k >= hold_k);
      tick();
      if (hold_k >= 0 && k == p_cur) begin
        k = 0;
        hold_k = -1;
        pulse_k = -1;
        start = 1'b0;
        first_done = -1;
      end else if (k > p_cur) begin
        break;
      end
    end
    start = 1'b0;
    track = 1'b0;
    chk("latency", 32'(first_done), 32'(p_cur));
    repeat (3) tick();
  endtask

  initial begin
    logic [15:0] ra, oa;
    reset_n = 1'b0;
    start = 1'b0;
    act = 0;
    msg_a = '0;
    out_a = '0;
    track = 1'b0;
    k = 0;
    p_cur = 0;
    b_cur = 0;
    first_done = -1;
    total = 0;
    bad = 0;
    for (int i = 0; i < 65536; i++) img[i] = $urandom;
    img[16'h0100] = 32'h61626364;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) begin
      chk("rst_done0", 32'(done_v[g]), 32'd1);
      chk("rst_we0", 32'(we_v[g]), 32'd0);
      chk("rst_addr0", 32'(addr_v[g]), 32'd0);
      chk("rst_wd0", wd_v[g], 32'd0);
    end
    reset_n = 1'b1;
    tick();

    compute_expected(1, 16'h0100);
    for (int j = 0; j < 8; j++) chk("model_abcd", exp_dg[j], ABCD[j]);

    run(0, 16'h0100, 16'h0200, -1, -1, -1);
    for (int j = 0; j < 8; j++) chk("abcd_mem", wr_cap[j], ABCD[j]);

    for (int r = 0; r < 2; r++) begin
      for (int g = 1; g < 4; g++) begin
        ra = 16'($urandom);
        oa = 16'($urandom);
        run(g, ra, oa, -1, -1, -1);
      end
    end

    ra = 16'h1234;
    oa = 16'h5670;
    run(1, ra, oa, -1, -1, 47);
    run(1, ra, oa, -1, -1, -1);

    run(1, 16'h2000, 16'h3000, 40, 120, -1);

    run(1, 16'hFFF8, 16'h4000, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
